// File: rtl/count_checker.sv
// count_checker
//   Consumer-side sequence checker for a free-running binary counter. Each
//   enabled sample of cnt_in is compared with the previous sample plus one
//   (modulo 2^WIDTH). Lock, wrap and error events are reported. All outputs
//   come from registers.
//
//   Optional feature macro: COUNT_CHK_STICKY_EN
//     defined   : ERROR is sticky until clr or reset.
//     undefined : ERROR re-acquires automatically, like SEARCH with match_cnt=0.
//
// Parameters
//   WIDTH     width of the checked count
//   LOCK_CNT  consecutive correct increments needed for lock (1..15)
//   ERR_W     width of the saturating error counter
//
// Ports
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   en         in   sample qualifier
//   clr        in   synchronous clear (FSM to IDLE, err_count to 0)
//   cnt_in     in   count value under check
//   locked     out  high while in LOCKED
//   err        out  one-cycle pulse on a mismatch seen in LOCKED
//   wrap       out  one-cycle pulse on a correct all-ones -> zero step in LOCKED
//   err_count  out  saturating error count
//   state      out  IDLE=0, SEARCH=1, LOCKED=2, ERROR=3
module count_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       match_q, match_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] expected;
    logic             hit;
    logic [3:0]       match_inc;

    assign expected  = prev_q + WIDTH'(1);
    assign hit       = (cnt_in == expected);
    assign match_inc = match_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        match_d  = match_q;
        errcnt_d = errcnt_q;
        err_d    = 1'b0;
        wrap_d   = 1'b0;

        if (clr) begin
            // clr wins over en; prev deliberately keeps its value
            state_d  = IDLE;
            match_d  = '0;
            errcnt_d = '0;
        end else if (en) begin
            prev_d = cnt_in;
            case (state_q)
                IDLE: begin
                    // capture-only edge, no compare
                    match_d = '0;
                    state_d = SEARCH;
                end
                SEARCH: begin
                    if (hit) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_V) state_d = LOCKED;
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        wrap_d = (&prev_q) && (cnt_in == '0);
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                        if (!(&errcnt_q)) errcnt_d = errcnt_q + ERR_W'(1);
                    end
                end
                ERROR: begin
`ifdef COUNT_CHK_STICKY_EN
                    state_d = ERROR;
`else
                    // same as SEARCH entered with match_cnt = 0
                    if (hit) begin
                        match_d = 4'd1;
                        state_d = (LOCK_V == 4'd1) ? LOCKED : SEARCH;
                    end else begin
                        match_d = '0;
                        state_d = SEARCH;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            match_q  <= '0;
            errcnt_q <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            match_q  <= match_d;
            errcnt_q <= errcnt_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign wrap      = wrap_q;
    assign err_count = errcnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker
//   Scoreboard bench for count_checker (WIDTH=4, LOCK_CNT=3, ERR_W=2).
//   Expected outputs are produced by a bench-side reference model when each
//   sample is driven, queued, and compared one cycle later against the DUT.
//   Directed checks cover reset, lock, wrap, error, gating, saturation, clr
//   priority and asynchronous reset.
module tb_count_checker;

    localparam int W    = 4;
    localparam int LOCK = 3;
    localparam int EW   = 2;
    localparam int MODV = 16;
    localparam int ESAT = 3;

`ifdef COUNT_CHK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          en;
    logic          clr;
    logic [W-1:0]  cnt_in;
    logic          locked;
    logic          err;
    logic          wrap;
    logic [EW-1:0] err_count;
    logic [1:0]    state;

    count_checker #(
        .WIDTH   (W),
        .LOCK_CNT(LOCK),
        .ERR_W   (EW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .clr      (clr),
        .cnt_in   (cnt_in),
        .locked   (locked),
        .err      (err),
        .wrap     (wrap),
        .err_count(err_count),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        int st;
        int e;
        int w;
        int ec;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_state, m_prev, m_match, m_errc;
    int err_pulses;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_prev  = 0;
        m_match = 0;
        m_errc  = 0;
        q.delete();
    endtask

    function automatic exp_t model_step(input bit e, input bit c, input int v);
        exp_t r;
        bit ok;
        r.e = 0;
        r.w = 0;
        if (c) begin
            m_state = 0;
            m_match = 0;
            m_errc  = 0;
        end else if (e) begin
            ok = (v == ((m_prev + 1) % MODV));
            if (m_state == 0) begin
                m_state = 1;
                m_match = 0;
            end else if (m_state == 1) begin
                m_match = ok ? m_match + 1 : 0;
                if (m_match >= LOCK) m_state = 2;
            end else if (m_state == 2) begin
                if (ok) begin
                    r.w = (m_prev == MODV - 1 && v == 0) ? 1 : 0;
                end else begin
                    r.e = 1;
                    m_errc = (m_errc < ESAT) ? m_errc + 1 : ESAT;
                    m_state = 3;
                end
            end else if (!STICKY) begin
                m_match = ok ? 1 : 0;
                m_state = (ok && LOCK == 1) ? 2 : 1;
            end
            m_prev = v;
        end
        r.st = m_state;
        r.ec = m_errc;
        return r;
    endfunction

    // drive one cycle of stimulus, push expectation, compare after the edge
    task automatic drive(input bit e, input bit c, input int v);
        exp_t x;
        en     = e;
        clr    = c;
        cnt_in = W'(v);
        q.push_back(model_step(e, c, v));
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            x = q.pop_front();
            check("sb_state", int'(state), x.st);
            check("sb_locked", int'(locked), (x.st == 2) ? 1 : 0);
            check("sb_err", int'(err), x.e);
            check("sb_wrap", int'(wrap), x.w);
            check("sb_errcnt", int'(err_count), x.ec);
            if (err) err_pulses++;
        end
    endtask

    initial begin
        int p;
        en = 1'b0;
        clr = 1'b0;
        cnt_in = '0;
        rstn = 1'b0;
        err_pulses = 0;
        model_reset();

        // reset
        repeat (4) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_errcnt", int'(err_count), 0);
        rstn = 1'b1;

        // lock from reset
        for (int i = 0; i < 4; i++) drive(1, 0, i);
        check("lock_locked", int'(locked), 1);
        check("lock_state", int'(state), 2);

        // step to 15 then wrap
        for (int i = 4; i < 16; i++) drive(1, 0, i);
        drive(1, 0, 0);
        check("wrap_pulse", int'(wrap), 1);
        drive(1, 0, 1);
        check("wrap_once", int'(wrap), 0);

        // error and recovery
        for (int i = 2; i < 7; i++) drive(1, 0, i);
        drive(1, 0, 8);
        check("err_pulse", int'(err), 1);
        check("err_cnt1", int'(err_count), 1);
        for (int i = 9; i < 13; i++) drive(1, 0, i);
        check("recov_state", int'(state), STICKY ? 3 : 2);

        // clr with en=1 and mismatch: clr wins
        drive(1, 1, 3);
        check("clr_state", int'(state), 0);
        check("clr_errcnt", int'(err_count), 0);
        check("clr_err", int'(err), 0);

        // enable gating
        for (int i = 5; i < 9; i++) drive(1, 0, i);
        check("gate_locked", int'(locked), 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 9);
        drive(1, 0, 9);
        drive(1, 0, 10);
        check("gate_noerr", int'(err), 0);
        check("gate_locked2", int'(locked), 1);

        // saturation: four errors with re-locks in between
        p = 10;
        err_pulses = 0;
        for (int k = 0; k < 4; k++) begin
            p = (p + 5) % MODV;
            drive(1, 0, p);
            for (int j = 0; j < 3; j++) begin
                p = (p + 1) % MODV;
                drive(1, 0, p);
            end
        end
        check("sat_pulses", err_pulses, STICKY ? 1 : 4);
        check("sat_errcnt", int'(err_count), STICKY ? 1 : 3);

        drive(1, 1, (p + 7) % MODV);
        check("clr2_state", int'(state), 0);
        check("clr2_errcnt", int'(err_count), 0);
        check("clr2_err", int'(err), 0);

        // asynchronous reset while locked
        for (int i = 0; i < 4; i++) drive(1, 0, i);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("arst_locked", int'(locked), 0);
        check("arst_state", int'(state), 0);
        #1;
        rstn = 1'b1;

        // asynchronous reset right after an error pulse
        for (int i = 4; i < 8; i++) drive(1, 0, i);
        drive(1, 0, 12);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("arst_err", int'(err), 0);
        check("arst_errcnt", int'(err_count), 0);
        check("arst_wrap", int'(wrap), 0);
        check("arst_locked2", int'(locked), 0);
        #1;
        rstn = 1'b1;

        // first enabled edge after release is capture only
        drive(1, 0, 9);
        drive(1, 0, 3);
        check("post_rst_state", int'(state), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
